r22sdf_ctrl: RTL and testbench

R22SDF_CTRL -- requirements
Module: r22sdf_ctrl

---
 rtl/r22sdf_ctrl.sv | 164 ++++++++++++++++
 tb/tb_r22sdf_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/r22sdf_ctrl.sv
// r22sdf_ctrl: sequencing for a radix-2^2 single-path delay-feedback FFT (selects, twiddle addresses, framing).
// Define R22SDF_CTRL_FLUSH_EN to compile in the FLUSH state that self-drains the pipeline after an input gap.
module r22sdf_ctrl #(
    parameter int FFT_LOG2 = 8,
    parameter int TW_LAT   = 1
) (
    input  logic                                 sys_clk,
    input  logic                                 sys_nrst,
    input  logic                                 sys_en,
    input  logic                                 din_valid,
    input  logic                                 din_sof,
    output logic                                 pipe_en,
    output logic [FFT_LOG2/2-1:0]                bf2i_sel,
    output logic [FFT_LOG2/2-1:0]                bf2ii_sel,
    output logic [FFT_LOG2/2-1:0]                bf2ii_swap,
    output logic [(FFT_LOG2/2-1)*FFT_LOG2-1:0]   tw_addr,
    output logic                                 dout_valid,
    output logic                                 dout_sof,
    output logic                                 busy
);

    localparam int N     = 1 << FFT_LOG2;
    localparam int S     = FFT_LOG2 / 2;
    // The last stage has no twiddle multiplier, so its latency is not added to the output offset.
    localparam int A_OUT = N - 1 + (S - 1) * TW_LAT;
    localparam logic [FFT_LOG2:0]   A_OUT_E  = (FFT_LOG2 + 1)'(A_OUT);
    localparam logic [FFT_LOG2-1:0] A_OUT_PH = FFT_LOG2'(A_OUT % N);

    function automatic int stage_off(input int s);
        return N - (N >> (2 * s)) + s * TW_LAT;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
`ifdef R22SDF_CTRL_FLUSH_EN
        ,
        FLUSH
`endif
    } state_t;

    state_t              state, state_nxt;
    logic [FFT_LOG2-1:0] ph;
    logic [FFT_LOG2:0]   elapsed;
    logic [FFT_LOG2-1:0] k_ph;
    logic [FFT_LOG2:0]   k_el;
    logic                reached;
    logic                flushing;

    logic [S-1:0]                bf2i_nxt, bf2ii_nxt, swap_nxt;
    logic [(S-1)*FFT_LOG2-1:0]   tw_nxt;

    // A new frame always restarts the phase at zero; elapsed saturates once the output is reached.
    always_comb begin
        k_ph    = (state == IDLE) ? '0 : ph;
        k_el    = (state == IDLE) ? '0 : elapsed;
        reached = (state != IDLE) && (elapsed == A_OUT_E);
    end

`ifdef R22SDF_CTRL_FLUSH_EN
    localparam logic [FFT_LOG2:0] FLUSH_LAST = A_OUT_E - 1'b1;
    logic [FFT_LOG2:0] flush_cnt;
    logic              gap;
    assign flushing = (state == FLUSH);
    assign gap      = sys_en & ~din_valid & (ph == '0);
`else
    assign flushing = 1'b0;
`endif

    assign pipe_en = sys_nrst & sys_en &
                     ((din_valid & ((state != IDLE) | din_sof)) | flushing);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pipe_en) state_nxt = FILL;
            FILL: begin
                if (pipe_en && reached) state_nxt = RUN;
`ifdef R22SDF_CTRL_FLUSH_EN
                else if (gap) state_nxt = FLUSH;
`endif
            end
            RUN: begin
`ifdef R22SDF_CTRL_FLUSH_EN
                if (gap) state_nxt = FLUSH;
`endif
            end
`ifdef R22SDF_CTRL_FLUSH_EN
            FLUSH: if (pipe_en && flush_cnt == FLUSH_LAST) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_nrst) begin
            state <= IDLE;
        end else if (sys_en) begin
            state <= state_nxt;
        end
    end

    // Each element's counter is the global phase minus that element's arrival offset, modulo its span.
    for (genvar s = 0; s < S; s++) begin : g_stage
        localparam int W = FFT_LOG2 - 2 * s;
        localparam logic [FFT_LOG2-1:0] OFF_I  = FFT_LOG2'(stage_off(s) % N);
        localparam logic [FFT_LOG2-1:0] OFF_II = FFT_LOG2'((stage_off(s) + (N >> (2 * s + 1))) % N);
        logic [1:0] top_ii;
        assign top_ii       = 2'((k_ph - OFF_II) >> (W - 2));
        assign bf2i_nxt[s]  = 1'((k_ph - OFF_I) >> (W - 1));
        assign bf2ii_nxt[s] = top_ii[0];
        assign swap_nxt[s]  = top_ii[1] & ~top_ii[0];

        if (s < S - 1) begin : g_tw
            localparam logic [FFT_LOG2-1:0] OFF_T =
                FFT_LOG2'((stage_off(s) + 3 * (N >> (2 * s + 2))) % N);
            logic [W-1:0]        ct;
            logic [FFT_LOG2-1:0] q, m;
            assign ct = W'(k_ph - OFF_T);
            assign q  = FFT_LOG2'({ct[W-2], ct[W-1]});
            assign m  = FFT_LOG2'(ct[W-3:0]);
            assign tw_nxt[s*FFT_LOG2 +: FFT_LOG2] = (q * m) << (2 * s);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_nrst) begin
            ph         <= '0;
            elapsed    <= '0;
            bf2i_sel   <= '0;
            bf2ii_sel  <= '0;
            bf2ii_swap <= '0;
            tw_addr    <= '0;
            dout_valid <= 1'b0;
            dout_sof   <= 1'b0;
            busy       <= 1'b0;
        end else if (sys_en) begin
            busy       <= (state_nxt != IDLE);
            dout_valid <= pipe_en & reached;
            dout_sof   <= pipe_en & reached & (k_ph == A_OUT_PH);
            if (pipe_en) begin
                ph         <= k_ph + 1'b1;
                elapsed    <= (k_el == A_OUT_E) ? A_OUT_E : k_el + 1'b1;
                bf2i_sel   <= bf2i_nxt;
                bf2ii_sel  <= bf2ii_nxt;
                bf2ii_swap <= swap_nxt;
                tw_addr    <= tw_nxt;
            end
        end
    end

`ifdef R22SDF_CTRL_FLUSH_EN
    always_ff @(posedge sys_clk) begin
        if (!sys_nrst) begin
            flush_cnt <= '0;
        end else if (sys_en) begin
            if (state == FLUSH) flush_cnt <= flush_cnt + 1'b1;
            else                flush_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_r22sdf_ctrl.sv
// Directed bench for r22sdf_ctrl at N=16, TW_LAT=1 (output offset 16); expectations come from the stage offsets
// 0/8/12 (stage 0) and 13/15 (stage 1) and the twiddle table for N=16.
`timescale 1ns/1ps
module tb_r22sdf_ctrl;
    localparam int FFT_LOG2 = 4;
    localparam int TW_LAT   = 1;
    localparam int S        = FFT_LOG2 / 2;

    logic sys_clk   = 1'b0;
    logic sys_nrst  = 1'b0;
    logic sys_en    = 1'b1;
    logic din_valid = 1'b0;
    logic din_sof   = 1'b0;
    logic                       pipe_en;
    logic [S-1:0]               bf2i_sel, bf2ii_sel, bf2ii_swap;
    logic [(S-1)*FFT_LOG2-1:0]  tw_addr;
    logic                       dout_valid, dout_sof, busy;
    logic                       last_pe;

    int n_compared   = 0;
    int n_mismatched = 0;
    int tw_table [16] = '{0, 0, 0, 0, 0, 2, 4, 6, 0, 1, 2, 3, 0, 3, 6, 9};

    r22sdf_ctrl #(.FFT_LOG2(FFT_LOG2), .TW_LAT(TW_LAT)) dut (
        .sys_clk    (sys_clk),
        .sys_nrst   (sys_nrst),
        .sys_en     (sys_en),
        .din_valid  (din_valid),
        .din_sof    (din_sof),
        .pipe_en    (pipe_en),
        .bf2i_sel   (bf2i_sel),
        .bf2ii_sel  (bf2ii_sel),
        .bf2ii_swap (bf2ii_swap),
        .tw_addr    (tw_addr),
        .dout_valid (dout_valid),
        .dout_sof   (dout_sof),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive one cycle of input, note the combinational pipe_en, then step past the rising edge.
    task automatic apply_stimulus(input logic valid, input logic sof);
        din_valid = valid;
        din_sof   = sof;
        #1;
        last_pe = pipe_en;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_model(input int k);
        int ci0, ci1, cii0, cii1, ct0;
        ci0  = k % 16;
        ci1  = (k + 64 - 13) % 4;
        cii0 = (k + 64 - 8) % 16;
        cii1 = (k + 64 - 15) % 4;
        ct0  = (k + 64 - 12) % 16;
        check_output("bf2i_sel", bf2i_sel, ((ci1 / 2) * 2) + (ci0 / 8));
        check_output("bf2ii_sel", bf2ii_sel, ((cii1 % 2) * 2) + ((cii0 / 4) % 2));
        check_output("bf2ii_swap", bf2ii_swap, ((cii1 == 2) ? 2 : 0) + ((cii0 / 4 == 2) ? 1 : 0));
        check_output("tw_addr", tw_addr, tw_table[ct0]);
        check_output("dout_valid", dout_valid, (k >= 16) ? 1 : 0);
        check_output("dout_sof", dout_sof, (k >= 16 && k % 16 == 0) ? 1 : 0);
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_bf2i"}, bf2i_sel, 0);
        check_output({tag, "_bf2ii"}, bf2ii_sel, 0);
        check_output({tag, "_swap"}, bf2ii_swap, 0);
        check_output({tag, "_tw"}, tw_addr, 0);
        check_output({tag, "_dv"}, dout_valid, 0);
        check_output({tag, "_sof"}, dout_sof, 0);
        check_output({tag, "_busy"}, busy, 0);
        check_output({tag, "_pipe_en"}, last_pe, 0);
    endtask

    initial begin
        int pe_cnt, dv_cnt, sof_cnt;

        sys_nrst = 1'b0;
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        check_reset_state("rst");
        sys_nrst = 1'b1;

        apply_stimulus(1'b1, 1'b0);
        check_output("idle_pipe_en", last_pe, 0);
        check_output("idle_busy", busy, 0);

        // Three back-to-back frames, a stray sof at sample 5, and a 5-cycle enable freeze after sample 20.
        for (int k = 0; k < 48; k++) begin
            if (k == 21) begin
                sys_en = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    apply_stimulus(1'b1, 1'b1);
                    check_output("frz_pipe_en", last_pe, 0);
                    check_model(20);
                end
                sys_en = 1'b1;
            end
            apply_stimulus(1'b1, (k % 16 == 0) || (k == 5));
            check_output("run_pipe_en", last_pe, 1);
            check_output("run_busy", busy, 1);
            check_model(k);
        end

        sys_en   = 1'b0;
        sys_nrst = 1'b0;
        apply_stimulus(1'b1, 1'b0);
        check_reset_state("midrst");
        sys_en   = 1'b1;
        sys_nrst = 1'b1;

        for (int k = 0; k < 16; k++) apply_stimulus(1'b1, k == 0);
        check_model(15);

        pe_cnt  = 0;
        dv_cnt  = 0;
        sof_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            apply_stimulus(1'b0, 1'b0);
            pe_cnt  += int'(last_pe);
            dv_cnt  += int'(dout_valid);
            sof_cnt += int'(dout_sof);
        end
`ifdef R22SDF_CTRL_FLUSH_EN
        check_output("flush_pipe_en_cycles", pe_cnt, 16);
        check_output("flush_dout_valid", dv_cnt, 16);
        check_output("flush_dout_sof", sof_cnt, 1);
        check_output("flush_busy", busy, 0);
`else
        check_output("gap_pipe_en_cycles", pe_cnt, 0);
        check_output("gap_dout_valid", dv_cnt, 0);
        check_output("gap_busy", busy, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
